// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: fixed XLEN+1 cycles accept-to-valid, one request in flight.
// No queueing: start is only taken while ready=1; flush kills CALC/FIX, rst overrides everything.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module muldiv_unit #(
  parameter int XLEN  = `DATA_WIDTH,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [2:0]                 op,
  input  logic [XLEN-1:0]            rs1,
  input  logic [XLEN-1:0]            rs2,
  input  logic [`REG_ADDR_WIDTH-1:0] rd_addr,
  input  logic                       flush,
  output logic                       ready,
  output logic                       valid,
  output logic [XLEN-1:0]            result,
  output logic [`REG_ADDR_WIDTH-1:0] rd_out
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                     state;
  logic [CNT_W-1:0]           cnt;
  logic [2:0]                 op_q;
  logic [`REG_ADDR_WIDTH-1:0] rd_q;
  logic                       sa_q;
  logic                       sb_q;
  logic                       bz_q;
  logic [XLEN-1:0]            a_orig;
  logic [XLEN-1:0]            opnd;   // multiplicand for MUL*, divisor for DIV*
  logic [XLEN-1:0]            acc;    // product high word / partial remainder
  logic [XLEN-1:0]            lo;     // multiplier -> product low word / dividend -> quotient

  logic                       in_sgn_a;
  logic                       in_sgn_b;
  logic [XLEN-1:0]            in_mag_a;
  logic [XLEN-1:0]            in_mag_b;
  logic [XLEN:0]              mul_sum;
  logic [XLEN:0]              rem_sh;
  logic [XLEN:0]              rem_diff;
  logic                       rem_ge;
  logic [2*XLEN-1:0]          prod;
  logic [2*XLEN-1:0]          prod_s;
  logic [XLEN-1:0]            quo;
  logic [XLEN-1:0]            rmd;
  logic [XLEN-1:0]            mul_res;
  logic [XLEN-1:0]            div_res;
  logic [XLEN-1:0]            fix_res;
  logic                       unused_bits;

  assign ready = (state == IDLE);

  // Signedness per funct3; MULHSU treats only rs1 as signed.
  always_comb begin
    in_sgn_a = 1'b0;
    in_sgn_b = 1'b0;
    if (op[2]) begin
      in_sgn_a = ~op[0] & rs1[XLEN-1];
      in_sgn_b = ~op[0] & rs2[XLEN-1];
    end else begin
      in_sgn_a = (op[1:0] != 2'b11) & rs1[XLEN-1];
      in_sgn_b = ~op[1] & rs2[XLEN-1];
    end
    in_mag_a = in_sgn_a ? -rs1 : rs1;
    in_mag_b = in_sgn_b ? -rs2 : rs2;
  end

  always_comb begin
    mul_sum  = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    rem_sh   = {acc, lo[XLEN-1]};
    rem_ge   = (rem_sh >= {1'b0, opnd});
    rem_diff = rem_sh - {1'b0, opnd};
  end

  // The remainder after a successful subtract is always below the divisor, so bit XLEN is zero.
  assign unused_bits = rem_diff[XLEN];

  always_comb begin
    prod    = {acc, lo};
    prod_s  = (sa_q ^ sb_q) ? -prod : prod;
    mul_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    quo     = (sa_q ^ sb_q) ? -lo : lo;
    rmd     = sa_q ? -acc : acc;
    if (bz_q)
      div_res = op_q[1] ? a_orig : {XLEN{1'b1}};
    else
      div_res = op_q[1] ? rmd : quo;
    fix_res = op_q[2] ? div_res : mul_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      valid  <= 1'b0;
      result <= '0;
      rd_out <= '0;
      cnt    <= '0;
      op_q   <= '0;
      rd_q   <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      bz_q   <= 1'b0;
      a_orig <= '0;
      opnd   <= '0;
      acc    <= '0;
      lo     <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            op_q   <= op;
            rd_q   <= rd_addr;
            sa_q   <= in_sgn_a;
            sb_q   <= in_sgn_b;
            bz_q   <= (rs2 == '0);
            a_orig <= rs1;
            opnd   <= op[2] ? in_mag_b : in_mag_a;
            lo     <= op[2] ? in_mag_a : in_mag_b;
            acc    <= '0;
            cnt    <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            if (op_q[2]) begin
              acc <= rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
              lo  <= {lo[XLEN-2:0], rem_ge};
            end else begin
              acc <= mul_sum[XLEN:1];
              lo  <= {mul_sum[0], lo[XLEN-1:1]};
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(XLEN - 1))
              state <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            result <= fix_res;
            rd_out <= rd_q;
            valid  <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
